// File: rtl/cussen_pkg.sv
// Shared definitions for the cussen datapath: the FSM state encoding, the overflow
// mode constants and the pointer/count width helpers.
package cussen_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SCAN    = 3'd1,
      ST_MULT    = 3'd2,
      ST_SCATTER = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   localparam int SAT_TRUNC = 32'sd0;
   localparam int SAT_CLAMP = 32'sd1;

   // A one-entry table still needs a one-bit pointer field.
   function automatic int ptr_w(input int n);
      return (n < 32'sd2) ? 32'sd1 : $clog2(n);
   endfunction

   function automatic int cnt_w(input int n);
      return $clog2(n + 32'sd1);
   endfunction

endpackage

// File: rtl/cussen_scale_unit.sv
// Registered W x W multiplier whose full product is reduced to OW bits, either by
// keeping the low bits or by clamping to the all-ones maximum.
module cussen_scale_unit
   import cussen_pkg::*;
#(
   parameter int W   = 8,
   parameter int OW  = 8,
   parameter int SAT = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   output logic [OW-1:0] q
);

   // Wide enough for the full product and for the output width, whichever is larger.
   localparam int XW = (2 * W > OW) ? 2 * W : OW;

   logic [XW-1:0] full_s;
   logic [OW-1:0] q_r;

   function automatic logic [OW-1:0] reduce(input logic [XW-1:0] full);
      if ((SAT == SAT_CLAMP) && (full > XW'({OW{1'b1}}))) begin
         reduce = {OW{1'b1}};
      end else begin
         reduce = OW'(full);
      end
   endfunction

   assign full_s = XW'(a) * XW'(b);
   assign q      = q_r;

   // Product register, loaded once per multiply cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_r <= '0;
      end else if (en) begin
         q_r <= reduce(full_s);
      end else begin
         q_r <= q_r;
      end
   end

endmodule

// File: rtl/cussen_dedup_scaler.sv
// Repeat-aware vector scaler: finds the distinct element values, multiplies only
// those by the scalar through one shared multiplier, and scatters the products back.
module cussen_dedup_scaler
   import cussen_pkg::*;
#(
   parameter int  N   = 9,
   parameter int  W   = 8,
   parameter int  OW  = 8,
   parameter int  SAT = 0,
   localparam int PW  = ptr_w(N),
   localparam int CW  = cnt_w(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*W-1:0]  in_data,
   input  logic [W-1:0]    scalar,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N*OW-1:0] out_data,
   output logic [N*PW-1:0] pointers,
   output logic [CW-1:0]   unique_count
);

   state_t          state_r, state_s;
   logic [W-1:0]    elem_r [N];
   logic [W-1:0]    uniq_r [N];
   logic [PW-1:0]   ptr_r  [N];
   logic [OW-1:0]   prod_r [N];
   logic [W-1:0]    scalar_r;
   logic [PW-1:0]   idx_r, k_r, pend_k_r;
   logic [CW-1:0]   u_r;
   logic            pend_v_r;
   logic            in_ready_r, out_valid_r;
   logic [N*OW-1:0] out_data_r;
   logic [N*PW-1:0] pointers_r;
   logic [CW-1:0]   ucnt_r;
   logic            accept_s, hit_s;
   logic [PW-1:0]   hit_idx_s;
   logic [W-1:0]    cur_s;
   logic [OW-1:0]   mul_q_s;
   logic [OW-1:0]   scat_s [N];

   assign accept_s     = in_valid && in_ready_r;
   assign in_ready     = in_ready_r;
   assign out_valid    = out_valid_r;
   assign out_data     = out_data_r;
   assign pointers     = pointers_r;
   assign unique_count = ucnt_r;

   cussen_scale_unit #(.W(W), .OW(OW), .SAT(SAT)) u_scale (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (state_r == ST_MULT),
      .a     (uniq_r[k_r]),
      .b     (scalar_r),
      .q     (mul_q_s)
   );

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE:    if (accept_s) state_s = ST_SCAN; else state_s = state_r;
         ST_SCAN:    if (idx_r == PW'(N - 1)) state_s = ST_MULT; else state_s = state_r;
         ST_MULT:    if (CW'(k_r) == u_r - CW'(1)) state_s = ST_SCATTER; else state_s = state_r;
         ST_SCATTER: state_s = ST_DONE;
         ST_DONE:    if (out_ready) state_s = ST_IDLE; else state_s = state_r;
         default:    state_s = ST_IDLE;
      endcase
   end

   // Parallel compare of the current element against the filled table entries;
   // scanning downwards leaves the lowest matching entry as the winner.
   always_comb begin
      cur_s     = elem_r[idx_r];
      hit_s     = 1'b0;
      hit_idx_s = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if ((CW'(j) < u_r) && (uniq_r[j] == cur_s)) begin
            hit_s     = 1'b1;
            hit_idx_s = PW'(j);
         end else begin
            hit_s     = hit_s;
            hit_idx_s = hit_idx_s;
         end
      end
   end

   // The last product is still in the multiplier register during SCATTER, so bypass it.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         if (pend_v_r && (ptr_r[i] == pend_k_r)) begin
            scat_s[i] = mul_q_s;
         end else begin
            scat_s[i] = prod_r[ptr_r[i]];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= ST_IDLE;
      else        state_r <= state_s;
   end

   // Working copy of the vector, unique/pointer/product tables and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            elem_r[i] <= '0;
            uniq_r[i] <= '0;
            ptr_r[i]  <= '0;
            prod_r[i] <= '0;
         end
         scalar_r <= '0;
         idx_r    <= '0;
         k_r      <= '0;
         u_r      <= '0;
         pend_v_r <= 1'b0;
         pend_k_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  for (int i = 0; i < N; i++) begin
                     elem_r[i] <= in_data[i*W +: W];
                     uniq_r[i] <= '0;
                  end
                  scalar_r <= scalar;
                  idx_r    <= '0;
                  u_r      <= '0;
               end
            end
            ST_SCAN: begin
               if (hit_s) begin
                  ptr_r[idx_r] <= hit_idx_s;
               end else begin
                  uniq_r[PW'(u_r)] <= cur_s;
                  ptr_r[idx_r]     <= PW'(u_r);
                  u_r              <= u_r + CW'(1);
               end
               idx_r <= idx_r + PW'(1);
               k_r   <= '0;
            end
            ST_MULT: k_r <= k_r + PW'(1);
            default: k_r <= k_r;
         endcase
         pend_v_r <= (state_r == ST_MULT);
         pend_k_r <= k_r;
         if (pend_v_r) prod_r[pend_k_r] <= mul_q_s;
      end
   end

   // Handshake flags and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         pointers_r  <= '0;
         ucnt_r      <= '0;
      end else begin
         in_ready_r  <= (state_s == ST_IDLE);
         out_valid_r <= (state_s == ST_DONE);
         if (state_r == ST_SCATTER) begin
            for (int i = 0; i < N; i++) begin
               out_data_r[i*OW +: OW] <= scat_s[i];
               pointers_r[i*PW +: PW] <= ptr_r[i];
            end
            ucnt_r <= u_r;
         end
      end
   end

endmodule

// File: tb/tb_cussen_dedup_scaler.sv
// Scoreboard bench: three builds (truncate, saturate, 16-bit output) share one stimulus;
// a negedge monitor pops expectations when out_valid rises and checks while it is held.
module tb_cussen_dedup_scaler;

   localparam int N = 9;
   localparam int W = 8;

   typedef struct packed {
      logic [N-1:0][15:0] prod;
      logic [N-1:0][15:0] ptr;
      logic [15:0]        u;
      logic [15:0]        lat;
      logic [31:0]        acc;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           out_ready = 1'b1;
   logic [N*W-1:0] in_data = '0;
   logic [W-1:0]   scalar = '0;

   logic           in_ready, in_ready_s, in_ready_w;
   logic           out_valid, out_valid_s, out_valid_w;
   logic [N*8-1:0] od_t, od_s;
   logic [N*16-1:0] od_w;
   logic [N*4-1:0] ptrs, ptrs_s, ptrs_w;
   logic [3:0]     ucnt, ucnt_s, ucnt_w;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   exp_t q[$];

   cussen_dedup_scaler #(.N(N), .W(W), .OW(8), .SAT(0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .scalar(scalar), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(od_t), .pointers(ptrs), .unique_count(ucnt));

   cussen_dedup_scaler #(.N(N), .W(W), .OW(8), .SAT(1)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_data(in_data), .scalar(scalar), .out_valid(out_valid_s), .out_ready(out_ready),
      .out_data(od_s), .pointers(ptrs_s), .unique_count(ucnt_s));

   cussen_dedup_scaler #(.N(N), .W(W), .OW(16), .SAT(0)) dut_wide (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
      .in_data(in_data), .scalar(scalar), .out_valid(out_valid_w), .out_ready(out_ready),
      .out_data(od_w), .pointers(ptrs_w), .unique_count(ucnt_w));

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [N-1:0][15:0] v9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
      return {16'(a8), 16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
   endfunction

   // Present a vector, hold it until accepted, then scramble the inputs.
   task automatic send(input logic [N-1:0][15:0] vec, input int sc,
                       input logic [N-1:0][15:0] prod, input logic [N-1:0][15:0] ptr,
                       input int u, input int lat, input bit expect_it);
      exp_t e;
      int   waited;
      @(negedge clk);
      in_valid = 1'b1;
      for (int i = 0; i < N; i++) in_data[i*W +: W] = vec[i][7:0];
      scalar = W'(sc);
      waited = 0;
      while (!in_ready && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 256'd0, 256'd1);
      end else if (expect_it) begin
         e.prod = prod; e.ptr = ptr; e.u = 16'(u); e.lat = 16'(lat); e.acc = 32'(cyc + 1);
         q.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom, $urandom};
      scalar   = W'($urandom);
   endtask

   task automatic drain();
      int w = 0;
      while ((q.size() != 0 || out_valid) && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (q.size() != 0 || out_valid) chk("drain_timeout", 256'd0, 256'd1);
   endtask

   // Monitor: pop on the rising out_valid, then check every held cycle.
   initial begin
      exp_t             cur;
      bit               seen = 1'b0;
      bit               have = 1'b0;
      logic [N*8-1:0]   e_t, e_s;
      logic [N*16-1:0]  e_w;
      logic [N*4-1:0]   e_p;
      forever begin
         @(negedge clk);
         if (!out_valid) begin
            seen = 1'b0;
            have = 1'b0;
         end else begin
            if (!seen) begin
               seen = 1'b1;
               if (q.size() == 0) begin
                  chk("unexpected_out_valid", 256'd1, 256'd0);
               end else begin
                  cur  = q.pop_front();
                  have = 1'b1;
                  chk("latency", 256'(cyc - int'(cur.acc)), 256'(cur.lat));
               end
            end
            if (have) begin
               for (int i = 0; i < N; i++) begin
                  e_t[i*8 +: 8]   = cur.prod[i][7:0];
                  e_s[i*8 +: 8]   = (cur.prod[i] > 16'd255) ? 8'd255 : cur.prod[i][7:0];
                  e_w[i*16 +: 16] = cur.prod[i];
                  e_p[i*4 +: 4]   = cur.ptr[i][3:0];
               end
               chk("out_data_trunc", 256'(od_t), 256'(e_t));
               chk("out_data_sat", 256'(od_s), 256'(e_s));
               chk("out_data_wide", 256'(od_w), 256'(e_w));
               chk("pointers", 256'(ptrs), 256'(e_p));
               chk("unique_count", 256'(ucnt), 256'(cur.u));
               chk("in_ready_while_valid", 256'(in_ready), 256'd0);
            end
         end
      end
   end

   initial begin
      logic [N-1:0][15:0] mixed, mixed_p, mixed_x2, idx_p, zero9;
      mixed    = v9(3, 1, 4, 1, 5, 9, 1, 1, 1);
      mixed_p  = v9(0, 1, 2, 1, 3, 4, 1, 1, 1);
      mixed_x2 = v9(6, 2, 8, 2, 10, 18, 2, 2, 2);
      idx_p    = v9(0, 1, 2, 3, 4, 5, 6, 7, 8);
      zero9    = '0;

      #3;
      chk("rst_in_ready", 256'(in_ready), 256'd0);
      chk("rst_out_valid", 256'(out_valid), 256'd0);
      chk("rst_out_data", 256'(od_t), 256'd0);
      chk("rst_pointers", 256'(ptrs), 256'd0);
      chk("rst_unique_count", 256'(ucnt), 256'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", 256'(in_ready), 256'd1);

      send(v9(9, 9, 9, 9, 9, 9, 9, 9, 9), 9, v9(81, 81, 81, 81, 81, 81, 81, 81, 81),
           zero9, 1, 11, 1'b1);
      send(v9(5, 3, 8, 1, 2, 9, 7, 6, 4), 2, v9(10, 6, 16, 2, 4, 18, 14, 12, 8),
           idx_p, 9, 19, 1'b1);
      send(mixed, 2, mixed_x2, mixed_p, 5, 15, 1'b1);
      send(v9(200, 200, 200, 200, 200, 200, 200, 200, 200), 2,
           v9(400, 400, 400, 400, 400, 400, 400, 400, 400), zero9, 1, 11, 1'b1);
      send(mixed, 0, zero9, mixed_p, 5, 15, 1'b1);
      drain();

      // Back-pressure with a second vector waiting upstream.
      out_ready = 1'b0;
      send(mixed, 2, mixed_x2, mixed_p, 5, 15, 1'b1);
      fork
         send(v9(9, 9, 9, 9, 9, 9, 9, 9, 9), 9, v9(81, 81, 81, 81, 81, 81, 81, 81, 81),
              zero9, 1, 11, 1'b1);
         begin
            int w = 0;
            while (!out_valid && w < 60) begin
               @(negedge clk);
               w++;
            end
            chk("bp_out_valid_seen", 256'(out_valid), 256'd1);
            repeat (5) begin
               @(negedge clk);
               chk("bp_out_valid_held", 256'(out_valid), 256'd1);
               chk("bp_in_ready", 256'(in_ready), 256'd0);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset while the multiplier is busy; the aborted vector must produce nothing.
      send(mixed, 2, zero9, zero9, 0, 0, 1'b0);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 256'(out_valid), 256'd0);
      chk("mid_rst_out_data", 256'(od_t), 256'd0);
      chk("mid_rst_pointers", 256'(ptrs), 256'd0);
      chk("mid_rst_unique_count", 256'(ucnt), 256'd0);
      chk("mid_rst_in_ready", 256'(in_ready), 256'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) begin
         @(negedge clk);
         chk("no_out_after_abort", 256'(out_valid), 256'd0);
      end
      send(mixed, 2, mixed_x2, mixed_p, 5, 15, 1'b1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cussen_dedup_scaler.md
# cussen_dedup_scaler

Parametrised repeat-aware vector scaler for the cussen datapath. It accepts an N-element vector plus a scalar and detects repeated element values. Only the unique values go through a single shared multiplier, and the products are scattered back to every position. Duplicate-heavy vectors therefore cost fewer multiply cycles. It also reports the unique count and per-element pointers.

## Interface
- `N`, 9, vector element count (N ≥ 2)
- `W`, 8, element and scalar width
- `OW`, 8, product/output element width
- `SAT`, 0, overflow mode: 0 = truncate (keep low OW bits), 1 = saturate to 2^OW−1
- `PW`, $clog2(N), pointer width (derived localparam)
- `CW`, $clog2(N+1), count width (derived localparam)

Ports:
- `clk` in 1: clock, all state on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `in_valid` in 1: input vector and scalar valid
- `in_ready` out 1: block can accept a vector
- `in_data` in N*W: element i at [i*W +: W]
- `scalar` in W: multiplier operand
- `out_valid` out 1: results valid
- `out_ready` in 1: consumer accepts results
- `out_data` out N*OW: scaled element i at [i*OW +: OW]
- `pointers` out N*PW: index of element i's entry in the unique table
- `unique_count` out CW: number of distinct values, 1..N

## Operation
- States: IDLE → SCAN → MULT → SCATTER → DONE → IDLE.
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready, register in_data and scalar, clear the unique table, and set idx=0.
  - Next state: SCAN.
- **SCAN**, one element per cycle, idx = 0..N−1
  - Compare elem[idx] in parallel against the valid unique-table entries.
  - On a match at the lowest entry j: ptr[idx]=j.
  - On no match: append the value at entry U, set ptr[idx]=U, then U=U+1.
  - After idx=N−1, go to MULT with k=0.
- **MULT**, one multiply per cycle, k = 0..U−1
  - prod[k] = uniq[k]*scalar. The full 2W-bit product is reduced to OW per SAT.
  - After k=U−1, go to SCATTER.
- **SCATTER**, one cycle
  - out_data[i] = prod[ptr[i]] for all i.
  - pointers and unique_count are loaded.
  - Next state: DONE.
- **DONE**
  - out_valid=1; all outputs held stable.
  - On out_ready, go to IDLE. out_valid drops the same edge.
- Unique entries are ordered by first occurrence. ptr[0]=0 always.
- scalar=0 yields all-zero outputs. The normal cycle count still applies.

## Timing
- Reset values: in_ready=0 while rst_n low, then 1 (IDLE); out_valid=0; out_data=0; pointers=0; unique_count=0; internal tables and counters cleared.
- Accept at edge T. out_valid is high after edge T+N+U+1, so latency is N+U+1 cycles: min N+2 (U=1), max 2N+1.
- in_ready=1 only in IDLE. There is no overlap of transactions.
- A vector arriving while busy is not accepted. The upstream must hold it with in_valid high.
- out_valid held under back-pressure: while out_valid=1 && out_ready=0, outputs hold and in_ready stays 0.
- in_valid during DONE with out_ready=1: return to IDLE first; accept on the next cycle.
- Reset mid-operation: all state and outputs clear immediately. No out_valid is produced for the aborted vector.
- in_data and scalar are don't-care after the accept edge. The block works only on its registered copy.

## Structure
- Shared package `cussen_pkg`:
  - state encoding (IDLE/SCAN/MULT/SCATTER/DONE)
  - SAT mode constants
  - the pointer/count width helper functions
- Sub-module `cussen_scale_unit`: registered W×W multiply with truncate/saturate reduction to OW. It is instantiated once.
- Top holds the FSM, idx/k counters, unique table with N parallel comparators, pointer table and product table.

## Test plan
Default parameters (N=9, W=8, OW=8, SAT=0) unless stated.
- All-equal vector: in=9×{9}, scalar=9 → every out=81; U=1; all pointers 0; out_valid 11 cycles after accept.
- All-distinct vector: in={5,3,8,1,2,9,7,6,4}, scalar=2 → out={10,6,16,2,4,18,14,12,8}; U=9; pointers 0..8; latency 19.
- Mixed vector: in={3,1,4,1,5,9,1,1,1}, scalar=2 → out={6,2,8,2,10,18,2,2,2}; U=5; pointers={0,1,2,1,3,4,1,1,1}; latency 15.
- Overflow: in=9×{200}, scalar=2.
  - SAT=0 → every out=144.
  - Rebuilt with SAT=1 → every out=255.
  - Rebuilt with OW=16 → every out=400.
- Back-pressure and reset:
  - out_ready low for 5 cycles in DONE → outputs stable, in_ready=0, a pending in_valid is not accepted.
  - rst_n pulsed low during MULT → all outputs 0 and no out_valid.
  - The following mixed vector then completes correctly.
